// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback steps.
// Latency: 3-5 cycles per instruction plus memory wait cycles; outputs decode from the current state.
// Backpressure: mem_ready low holds FETCH, MEM_READ or MEM_WRITE indefinitely with strobes held steady.
//
// Ports:
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   op, funct, rt0         instruction fields IR[31:26], IR[5:0], IR[16]
//   mem_ready              memory access completes this cycle
//   IorD, Mem_read, Mem_write, IR_write, Reg_write, RegDst, MemtoReg,
//   ALUSrcA, ALUSrcB, ALU_op, AddrReg_write, PC_write, PC_write_cond,
//   condition, PC_source   datapath controls
//   illegal_op             one-cycle pulse on an undecodable opcode
//   state                  current FSM state (debug)

module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       rt0,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       Mem_read,
    output logic       Mem_write,
    output logic       IR_write,
    output logic       Reg_write,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALU_op,
    output logic       AddrReg_write,
    output logic       PC_write,
    output logic       PC_write_cond,
    output logic [2:0] condition,
    output logic [1:0] PC_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    // State encodings (visible on the debug port, so values are fixed)
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_IMM_EXEC  = 4'd10;
    localparam logic [3:0] S_IMM_WB    = 4'd11;
    localparam logic [3:0] S_JR        = 4'd12;
    localparam logic [3:0] S_ILLEGAL   = 4'd13;

    // Opcodes
    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    // ALU operand-B select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // ALU operation select
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_IMM   = 3'b011;
    localparam logic [2:0] ALU_PASSA = 3'b100;

    // PC source select
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_ADDR = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    // Branch condition select
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_NE  = 3'b010;
    localparam logic [2:0] COND_GEZ = 3'b011;
    localparam logic [2:0] COND_GTZ = 3'b100;
    localparam logic [2:0] COND_LEZ = 3'b101;
    localparam logic [2:0] COND_LTZ = 3'b110;

    logic [3:0] cur_state;
    logic [3:0] nxt_state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    assign state = cur_state;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH: begin
                nxt_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE:  nxt_state = (funct == FUNCT_JR) ? S_JR : S_EXECUTE;
                    OP_LW,
                    OP_SW:     nxt_state = S_MEM_ADDR;
                    OP_BEQ,
                    OP_BNE,
                    OP_BLEZ,
                    OP_BGTZ,
                    OP_REGIMM: nxt_state = S_BRANCH;
                    OP_J:      nxt_state = S_JUMP;
                    OP_ADDI,
                    OP_ANDI,
                    OP_ORI,
                    OP_SLTI:   nxt_state = S_IMM_EXEC;
                    default:   nxt_state = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                // Only lw/sw reach here; anything else falls back to FETCH.
                if (op == OP_LW) begin
                    nxt_state = S_MEM_READ;
                end else if (op == OP_SW) begin
                    nxt_state = S_MEM_WRITE;
                end else begin
                    nxt_state = S_FETCH;
                end
            end
            S_MEM_READ:  nxt_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    nxt_state = S_FETCH;
            S_MEM_WRITE: nxt_state = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   nxt_state = S_R_WB;
            S_R_WB:      nxt_state = S_FETCH;
            S_IMM_EXEC:  nxt_state = S_IMM_WB;
            S_IMM_WB:    nxt_state = S_FETCH;
            S_BRANCH:    nxt_state = S_FETCH;
            S_JUMP:      nxt_state = S_FETCH;
            S_JR:        nxt_state = S_FETCH;
            S_ILLEGAL:   nxt_state = S_FETCH;
            default:     nxt_state = S_FETCH;   // unused codes 14/15 recover
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        IorD          = 1'b0;
        Mem_read      = 1'b0;
        Mem_write     = 1'b0;
        IR_write      = 1'b0;
        Reg_write     = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        ALU_op        = ALU_ADD;
        AddrReg_write = 1'b0;
        PC_write      = 1'b0;
        PC_write_cond = 1'b0;
        condition     = 3'b000;
        PC_source     = PCSRC_ALU;
        illegal_op    = 1'b0;

        case (cur_state)
            S_FETCH: begin
                // PC+4 computed every fetch cycle; IR and PC only commit
                // on the cycle memory actually returns the instruction.
                Mem_read = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                IR_write = mem_ready;
                PC_write = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute and latch PC+4+(imm<<2) as branch target.
                ALUSrcB       = SRCB_IMM_SH;
                AddrReg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                Mem_read = 1'b1;
                IorD     = 1'b1;
            end
            S_MEM_WB: begin
                Reg_write = 1'b1;
                MemtoReg  = 1'b1;
            end
            S_MEM_WRITE: begin
                Mem_write = 1'b1;
                IorD      = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALU_op  = ALU_FUNCT;
            end
            S_R_WB: begin
                Reg_write = 1'b1;
                RegDst    = 1'b1;
            end
            S_IMM_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALU_op  = ALU_IMM;
            end
            S_IMM_WB: begin
                Reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                PC_write_cond = 1'b1;
                PC_source     = PCSRC_ADDR;
                // Two-register compares subtract A-B; compares against
                // zero just pass A through to the condition logic.
                case (op)
                    OP_BEQ: begin
                        condition = COND_EQ;
                        ALU_op    = ALU_SUB;
                    end
                    OP_BNE: begin
                        condition = COND_NE;
                        ALU_op    = ALU_SUB;
                    end
                    OP_BLEZ: begin
                        condition = COND_LEZ;
                        ALU_op    = ALU_PASSA;
                    end
                    OP_BGTZ: begin
                        condition = COND_GTZ;
                        ALU_op    = ALU_PASSA;
                    end
                    OP_REGIMM: begin
                        condition = rt0 ? COND_GEZ : COND_LTZ;
                        ALU_op    = ALU_PASSA;
                    end
                    default: begin
                        condition = 3'b000;
                    end
                endcase
            end
            S_JUMP: begin
                PC_write  = 1'b1;
                PC_source = PCSRC_JUMP;
            end
            S_JR: begin
                ALUSrcA  = 1'b1;
                ALU_op   = ALU_PASSA;
                PC_write = 1'b1;
            end
            S_ILLEGAL: begin
                // Single cycle in this state, so this is a one-cycle pulse.
                illegal_op = 1'b1;
            end
            default: begin
            end
        endcase

        // Reset overrides everything immediately, even mid-wait, so no
        // strobe can fire during the cycle reset is being applied.
        if (!rst_n) begin
            IorD          = 1'b0;
            Mem_read      = 1'b0;
            Mem_write     = 1'b0;
            IR_write      = 1'b0;
            Reg_write     = 1'b0;
            RegDst        = 1'b0;
            MemtoReg      = 1'b0;
            ALUSrcA       = 1'b0;
            ALUSrcB       = SRCB_REG;
            ALU_op        = ALU_ADD;
            AddrReg_write = 1'b0;
            PC_write      = 1'b0;
            PC_write_cond = 1'b0;
            condition     = 3'b000;
            PC_source     = PCSRC_ALU;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port list, clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- rt0  in  1  IR[16]; REGIMM select, 1 = bgez, 0 = bltz
- mem_ready  in  1  memory access completes this cycle
- IorD  out  1  0 = PC address, 1 = ALU-register address
- Mem_read, Mem_write, IR_write, Reg_write  out  1 each  strobes
- RegDst  out  1  1 = rd, 0 = rt
- MemtoReg  out  1  1 = memory data register, 0 = ALU register
- ALUSrcA  out  1  0 = PC, 1 = A register
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALU_op  out  3  000 add, 001 sub, 010 funct-decoded, 011 op-decoded immediate, 100 pass A
- AddrReg_write  out  1  latch branch target
- PC_write, PC_write_cond  out  1 each  feed PC-update logic
- condition  out  3  branch condition select
- PC_source  out  2  00 ALU/shift result, 01 AddrReg, 10 jump target
- illegal_op  out  1  one-cycle pulse on an undecodable opcode
- state  out  4  current state, for debug

Function
REQ-003 SHALL be a Moore FSM; outputs decode from state only, except the FETCH strobes gated by mem_ready.
REQ-004 State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11, JR 12, ILLEGAL 13. Codes 14 and 15 SHALL go to FETCH.
REQ-005 Any output not listed for a state SHALL be 0.
REQ-006 FETCH:
- Mem_read=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=000, PC_source=00.
- IR_write=PC_write=mem_ready.
- Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
REQ-007 DECODE: ALUSrcA=0, ALUSrcB=11, ALU_op=000, AddrReg_write=1. Next state by op:
- 000000: funct 001000 -> JR, otherwise EXECUTE
- 100011 or 101011 -> MEM_ADDR
- 000100, 000101, 000110, 000111 or 000001 -> BRANCH
- 000010 -> JUMP
- 001000, 001100, 001101 or 001010 -> IMM_EXEC
- any other op -> ILLEGAL
REQ-008 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_op=000. Next is MEM_READ for op 100011, MEM_WRITE for op 101011.
REQ-009 MEM_READ: Mem_read=1, IorD=1. Holds until mem_ready=1, then MEM_WB.
REQ-010 MEM_WB: Reg_write=1, RegDst=0, MemtoReg=1, then FETCH.
REQ-011 MEM_WRITE: Mem_write=1, IorD=1. Holds until mem_ready=1, then FETCH.
REQ-012 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALU_op=010, then R_WB.
REQ-013 R_WB: Reg_write=1, RegDst=1, MemtoReg=0, then FETCH.
REQ-014 IMM_EXEC: ALUSrcA=1, ALUSrcB=10, ALU_op=011, then IMM_WB.
REQ-015 IMM_WB: Reg_write=1, RegDst=0, MemtoReg=0, then FETCH.
REQ-016 BRANCH: ALUSrcA=1, PC_write_cond=1, PC_source=01, then FETCH. Per op:
- beq: condition 001, ALUSrcB=00, ALU_op=001
- bne: condition 010, ALUSrcB=00, ALU_op=001
- blez: condition 101, ALU_op=100
- bgtz: condition 100, ALU_op=100
- bgez: condition 011, ALU_op=100
- bltz: condition 110, ALU_op=100
REQ-017 JUMP: PC_write=1, PC_source=10, then FETCH.
REQ-018 JR: ALUSrcA=1, ALU_op=100, PC_source=00, PC_write=1, then FETCH.
REQ-019 ILLEGAL: illegal_op=1 for exactly one cycle, no write strobes, then FETCH.
REQ-020 Waiting on mem_ready SHALL have no timeout; strobes stay asserted steadily while waiting.

Reset
REQ-021 While rst_n=0 at a rising edge, the next state SHALL be FETCH, regardless of the current state, including mid-wait.
REQ-022 While rst_n=0, all write and read strobes SHALL be forced to 0 combinationally:
- IR_write, PC_write, PC_write_cond, Reg_write, Mem_write, Mem_read, AddrReg_write, illegal_op.
REQ-023 Reset values: state=0; all other outputs 0.

Verification
REQ-024 Apply the following directed scenarios; each bench SHALL check every output cycle by cycle.
- lw (op 100011), mem_ready=1 on the 2nd FETCH cycle and on the 1st MEM_READ cycle -> states 0,0,1,2,3,4,0; Reg_write=1 with MemtoReg=1 in state 4 only.
- add (op 0, funct 100000), mem_ready=1 -> states 0,1,6,7,0; ALU_op=010 in state 6; RegDst=1 in state 7.
- bgtz (op 000111) -> state 8 with condition=100, PC_write_cond=1, PC_source=01, ALU_op=100.
- bgez (op 000001, rt0=1) -> condition=011; with rt0=0 -> condition=110.
- jr (op 0, funct 001000) -> state 12 with PC_write=1, PC_source=00; j (op 000010) -> state 9 with PC_source=10.
- op 111111 -> state 13, then a single illegal_op pulse, then state 0.
- rst_n=0 asserted in state 3 while mem_ready=0 -> strobes drop to 0 immediately; state=0 after the edge.
